icap_reg_reader: RTL and testbench



---
 rtl/icap_reg_reader.sv | 125 ++++++++++++
 tb/tb_icap_reg_reader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/icap_reg_reader.sv
// icap_reg_reader: reads one configuration register through the Virtex-6 ICAP (X32) with sync/read header and DESYNC.
// Define ICAP_BITSWAP_EN to bit-reverse icap_i/icap_o within each byte; otherwise words pass straight through.
module icap_reg_reader #(
  parameter int READ_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  reg_addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        timeout_err,
  output logic        icap_csb,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  input  logic [31:0] icap_o,
  input  logic        icap_busy
);
  typedef enum logic [3:0] {IDLE, WR_HDR, GAP, TURN_RD, RD_WAIT, RD_END, TURN_WR, WR_DESYNC, DONE} state_t;
  state_t      state;
  logic [2:0]  idx;
  logic [9:0]  rd_cnt;
  logic [4:0]  addr;
  logic        to_flag;
  function automatic logic [31:0] swap(input logic [31:0] w);
`ifdef ICAP_BITSWAP_EN
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = w[{b[4:3], ~b[2:0]}];
    return r;
`else
    return w;
`endif
  endfunction
  function automatic logic [31:0] hdr_word(input logic [2:0] i, input logic [4:0] a);
    return i == 3'd0 ? 32'hFFFF_FFFF : i == 3'd1 ? 32'hAA99_5566 :
           i == 3'd3 ? (32'h2800_0001 | {14'd0, a, 13'd0}) : 32'h2000_0000;
  endfunction
  function automatic logic [31:0] desync_word(input logic [2:0] i);
    return i == 3'd0 ? 32'h3000_8001 : i == 3'd1 ? 32'h0000_000D : 32'h2000_0000;
  endfunction
  // Outputs are loaded together with the state so each one reflects the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 3'd0;
      rd_cnt      <= 10'd0;
      addr        <= 5'd0;
      to_flag     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_data     <= 32'd0;
      timeout_err <= 1'b0;
      icap_csb    <= 1'b1;
      icap_rdwrb  <= 1'b0;
      icap_i      <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state       <= WR_HDR;
          addr        <= reg_addr;
          idx         <= 3'd0;
          to_flag     <= 1'b0;
          timeout_err <= 1'b0;
          busy        <= 1'b1;
          icap_csb    <= 1'b0;
          icap_i      <= swap(hdr_word(3'd0, reg_addr));
        end
        WR_HDR: if (idx == 3'd5) begin
          state    <= GAP;
          icap_csb <= 1'b1;
          icap_i   <= 32'd0;
        end else begin
          idx    <= idx + 3'd1;
          icap_i <= swap(hdr_word(idx + 3'd1, addr));
        end
        GAP: begin
          state      <= TURN_RD;
          icap_rdwrb <= 1'b1;
        end
        TURN_RD: begin
          state    <= RD_WAIT;
          rd_cnt   <= 10'd0;
          icap_csb <= 1'b0;
        end
        // The first two read cycles are pipeline latency inside ICAP, so data is never taken before rd_cnt=2.
        RD_WAIT: if (rd_cnt >= 10'd2 && !icap_busy) begin
          state    <= RD_END;
          rd_data  <= swap(icap_o);
          icap_csb <= 1'b1;
        end else if (rd_cnt == 10'(READ_TIMEOUT - 1)) begin
          state    <= RD_END;
          to_flag  <= 1'b1;
          icap_csb <= 1'b1;
        end else begin
          rd_cnt <= rd_cnt + 10'd1;
        end
        RD_END: begin
          state      <= TURN_WR;
          icap_rdwrb <= 1'b0;
        end
        TURN_WR: begin
          state    <= WR_DESYNC;
          idx      <= 3'd0;
          icap_csb <= 1'b0;
          icap_i   <= swap(desync_word(3'd0));
        end
        WR_DESYNC: if (idx == 3'd3) begin
          state       <= DONE;
          icap_csb    <= 1'b1;
          icap_i      <= 32'd0;
          busy        <= 1'b0;
          done        <= 1'b1;
          timeout_err <= to_flag;
        end else begin
          idx    <= idx + 3'd1;
          icap_i <= swap(desync_word(idx + 3'd1));
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icap_reg_reader.sv
// tb_icap_reg_reader: randomized readback sequences against a cycle-offset model of the ICAP read protocol.
module tb_icap_reg_reader;
  localparam int T = 64;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [4:0]  reg_addr = 5'd0;
  logic        busy, done, timeout_err, icap_csb, icap_rdwrb;
  logic        icap_busy = 1'b1;
  logic [31:0] rd_data, icap_i;
  logic [31:0] icap_o = 32'd0;
  int          stall_cfg = 0, rdw = 0, n_chk = 0, n_fail = 0;
  logic [31:0] icap_word = 32'd0;
  bit          act = 1'b0, m_cap = 1'b0, te_m = 1'b0;
  int          off = 0, m_w = 0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_data = 32'd0, rd_m = 32'd0;
  logic        e_csb, e_rw, e_busy, e_done, e_te, p_csb = 1'b1, p_rw = 1'b0;
  logic [31:0] e_i, e_rd;
  always #5 clk = ~clk;
  icap_reg_reader #(.READ_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .start(start), .reg_addr(reg_addr), .busy(busy), .done(done),
    .rd_data(rd_data), .timeout_err(timeout_err), .icap_csb(icap_csb), .icap_rdwrb(icap_rdwrb),
    .icap_i(icap_i), .icap_o(icap_o), .icap_busy(icap_busy)
  );
  function automatic logic [31:0] bswap(input logic [31:0] w);
`ifdef ICAP_BITSWAP_EN
    logic [31:0] r;
    for (int y = 0; y < 4; y++)
      for (int b = 0; b < 8; b++) r[8*y+b] = w[8*y+7-b];
    return r;
`else
    return w;
`endif
  endfunction
  function automatic logic [31:0] hdr(input int k, input logic [4:0] a);
    return k == 0 ? 32'hFFFFFFFF : k == 1 ? 32'hAA995566 : k == 3 ? 32'h28000001 + (32'(a) << 13) : 32'h20000000;
  endfunction
  function automatic logic [31:0] desync(input int k);
    return k == 0 ? 32'h30008001 : k == 1 ? 32'h0000000D : 32'h20000000;
  endfunction
  function automatic int cap_idx(input int s);
    return s < 2 ? 2 : s;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic chk1(input string nm, input logic got, input logic exp);
    chk(nm, {31'd0, got}, {31'd0, exp});
  endtask
  // Sequence model: position in the current sequence (off) plus the RD_WAIT length decided at accept time.
  always @(posedge clk or posedge reset)
    if (reset) begin
      act <= 1'b0; off <= 0; rd_m <= 32'd0; te_m <= 1'b0;
    end else if (act) begin
      if (off == 14 + m_w) begin
        act <= 1'b0; rd_m <= m_cap ? m_data : rd_m; te_m <= !m_cap;
      end else off <= off + 1;
    end else if (start) begin
      act <= 1'b1; off <= 0; m_addr <= reg_addr; m_data <= icap_word;
      m_cap <= cap_idx(stall_cfg) < T;
      m_w <= cap_idx(stall_cfg) < T ? cap_idx(stall_cfg) + 1 : T;
    end
  // ICAP model: busy for the first stall_cfg read cycles, garbage on O while busy.
  initial forever begin
    @(negedge clk);
    if (icap_csb === 1'b0 && icap_rdwrb === 1'b1) begin
      icap_busy = rdw < stall_cfg;
      icap_o = icap_busy ? $urandom : bswap(icap_word);
      rdw++;
    end else begin
      rdw = 0; icap_busy = 1'b1; icap_o = $urandom;
    end
  end
  initial forever begin
    @(negedge clk);
    e_csb = 1'b1; e_rw = 1'b0; e_i = 32'd0; e_busy = act; e_done = 1'b0; e_rd = rd_m; e_te = act ? 1'b0 : te_m;
    if (act) begin
      if (off < 6) begin e_csb = 1'b0; e_i = bswap(hdr(off, m_addr)); end
      else if (off == 7 || off == 8 + m_w) e_rw = 1'b1;
      else if (off >= 8 && off < 8 + m_w) begin e_csb = 1'b0; e_rw = 1'b1; end
      else if (off >= 10 + m_w && off < 14 + m_w) begin e_csb = 1'b0; e_i = bswap(desync(off - 10 - m_w)); end
      else if (off == 14 + m_w) begin e_busy = 1'b0; e_done = 1'b1; e_te = !m_cap; end
      if (off >= 8 + m_w && m_cap) e_rd = m_data;
    end
    chk1("csb", icap_csb, e_csb);
    chk1("rdwrb", icap_rdwrb, e_rw);
    chk("icap_i", icap_i, e_i);
    chk1("busy", busy, e_busy);
    chk1("done", done, e_done);
    chk("rd_data", rd_data, e_rd);
    chk1("timeout_err", timeout_err, e_te);
    if (icap_rdwrb !== p_rw) chk1("rdwrb_turn_needs_csb_high", icap_csb & p_csb, 1'b1);
    if (icap_csb === 1'b1) chk("icap_i_zero_when_deselected", icap_i, 32'd0);
    p_csb = icap_csb; p_rw = icap_rdwrb;
  end
  task automatic run(input logic [4:0] a, input int s, input logic [31:0] d, output int cyc, output logic [31:0] h);
    @(negedge clk);
    reg_addr = a; stall_cfg = s; icap_word = d; start = 1'b1; cyc = 1; h = 32'd0;
    @(negedge clk);
    start = 1'b0; cyc = 2;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) h = bswap(icap_i);
    end
    chk1("done_within_bound", done, 1'b1);
  endtask
  initial begin
    int cyc, nd;
    logic [31:0] h;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk1("reset_csb", icap_csb, 1'b1);
    chk("reset_rd_data", rd_data, 32'd0);
    run(5'h07, 0, 32'h401079FC, cyc, h);
    chk("stat_done_cycle", cyc, 19);
    chk("stat_hdr_word", h, 32'h2800E001);
    chk("stat_rd_data", rd_data, 32'h401079FC);
    chk1("stat_no_timeout", timeout_err, 1'b0);
    run(5'h0C, 10, 32'h04244093, cyc, h);
    chk("idcode_done_cycle", cyc, 27);
    chk("idcode_rd_data", rd_data, 32'h04244093);
    run(5'h0C, 1000, 32'hDEADBEEF, cyc, h);
    chk("timeout_done_cycle", cyc, 80);
    chk1("timeout_flag", timeout_err, 1'b1);
    chk("timeout_keeps_rd_data", rd_data, 32'h04244093);
    run(5'h0E, 63, 32'h5A5A0F0F, cyc, h);
    chk("last_slot_done_cycle", cyc, 80);
    chk1("last_slot_no_timeout", timeout_err, 1'b0);
    chk("last_slot_rd_data", rd_data, 32'h5A5A0F0F);
    run(5'h0E, 64, 32'h11112222, cyc, h);
    chk1("past_last_slot_timeout", timeout_err, 1'b1);
    chk("past_last_slot_rd_data", rd_data, 32'h5A5A0F0F);
    @(negedge clk);
    reg_addr = 5'h03; stall_cfg = 0; icap_word = 32'hC0FFEE11; start = 1'b1; nd = 0;
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      if (k == 3) h = bswap(icap_i);
      nd += int'(done);
      reg_addr = 5'($urandom);
    end
    start = 1'b0;
    chk("spam_single_done", nd, 1);
    chk("spam_hdr_word", h, 32'h28006001);
    chk("spam_rd_data", rd_data, 32'hC0FFEE11);
    repeat (3) @(negedge clk);
    reg_addr = 5'h16; stall_cfg = 0; icap_word = 32'h12345678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk1("abort_csb", icap_csb, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    chk("abort_rd_data", rd_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run(5'h16, 2, 32'h87654321, cyc, h);
    chk("after_abort_done_cycle", cyc, 19);
    chk("after_abort_rd_data", rd_data, 32'h87654321);
    for (int n = 0; n < 24; n++) begin
      int s;
      s = (n % 4 == 3) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 12));
      run(5'($urandom), s, $urandom, cyc, h);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
